// File: rtl/uart_receive.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_receive : 8N1 UART receiver, LSB first, valid/ready byte output.    |
// | Revision     : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module uart_receive #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  input  logic       data_ready_in,
  output logic       framing_err_out,
  output logic       overrun_out,
  output logic       busy_out
);

  localparam int BIT_PERIOD = CLK_FREQ_HZ / BAUD_RATE;
  localparam int c_HALF     = BIT_PERIOD / 2;
  localparam int c_CNT_W    = $clog2(BIT_PERIOD);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIT_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(c_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic               r_rx_meta;
  logic               r_rx_s;
  logic               r_rx_prev;
  logic [1:0]         r_fill;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shreg;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_ferr;
  logic               r_ovr;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         w_shreg_nxt;
  logic               w_complete;
  logic               w_frame_err;
  logic               w_fall;
  logic               w_accept;

  // r_fill blocks edge detection until the sync chain holds real line samples,
  // so a line already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 2'd0;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign w_fall = (r_fill == 2'd3) & r_rx_prev & ~r_rx_s;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt + c_CNT_W'(1);
    w_idx_nxt   = r_bit_idx;
    w_shreg_nxt = r_shreg;
    w_complete  = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_bit_cnt == c_CNT_MID) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {r_rx_s, r_shreg[7:1]};
          w_idx_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_bit_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_complete  = r_rx_s;
          w_frame_err = ~r_rx_s;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'd0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign w_accept = r_valid & data_ready_in;

  // A completion coinciding with an accept reloads the holding register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_frame_err;
      r_ovr  <= w_complete & r_valid & ~data_ready_in;
      if (w_complete && (!r_valid || w_accept)) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out        = r_data;
  assign data_valid_out  = r_valid;
  assign framing_err_out = r_ferr;
  assign overrun_out     = r_ovr;
  assign busy_out        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_receive.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_receive : directed and randomized bench for uart_receive.        |
// | Revision        : 1.0 - initial release                                  |
// +--------------------------------------------------------------------------+
module tb_uart_receive;

  // Shortened bit time keeps the run brief; 3_686_400 / 115_200 = 32 clk/bit.
  localparam int CLK_HZ = 3_686_400;
  localparam int BAUD   = 115_200;
  localparam int BP     = CLK_HZ / BAUD;
  localparam int HALF   = BP / 2;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       rx_in = 1'b1;
  logic       data_ready_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       framing_err_out;
  logic       overrun_out;
  logic       busy_out;

  uart_receive #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) u_dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rx_in          (rx_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .framing_err_out(framing_err_out),
    .overrun_out    (overrun_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference: line samples per edge, frame decoded by offset from the start edge.
  bit         hist [0:15];
  int         m_edge;
  bit         m_busy;
  int         m_start;
  logic [7:0] m_shreg;
  logic [7:0] m_data;
  bit         m_valid, m_ferr, m_ovr;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_edge = 0; m_busy = 0; m_start = 0; m_shreg = 8'd0;
      m_data = 8'd0; m_valid = 0; m_ferr = 0; m_ovr = 0;
    end else begin
      bit complete, ferr, samp;
      int off, bit_no;
      complete = 0; ferr = 0;
      m_edge++;
      hist[m_edge % 16] = rx_in;
      if (m_busy) begin
        off  = m_edge - m_start;
        samp = hist[(m_edge - 2) % 16];
        if (off == HALF) begin
          if (samp) m_busy = 0;
        end else if (off > HALF && ((off - HALF) % BP) == 0) begin
          bit_no = (off - HALF) / BP - 1;
          if (bit_no < 8) m_shreg[bit_no] = samp;
          else begin
            m_busy = 0;
            if (samp) complete = 1; else ferr = 1;
          end
        end
      end else if (m_edge >= 4 && hist[(m_edge - 3) % 16] && !hist[(m_edge - 2) % 16]) begin
        m_busy  = 1;
        m_start = m_edge;
      end
      m_ovr  = complete && m_valid && !data_ready_in;
      m_ferr = ferr;
      if (complete && (!m_valid || data_ready_in)) begin
        m_data  = m_shreg;
        m_valid = 1;
      end else if (m_valid && data_ready_in) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      total++;
      if (data_valid_out !== m_valid || data_out !== m_data || framing_err_out !== m_ferr ||
          overrun_out !== m_ovr || busy_out !== m_busy) begin
        bad++;
        $display("FAIL cycle_compare cyc=%0d got v=%b d=%02h fe=%b ov=%b busy=%b want v=%b d=%02h fe=%b ov=%b busy=%b",
                 cyc, data_valid_out, data_out, framing_err_out, overrun_out, busy_out,
                 m_valid, m_data, m_ferr, m_ovr, m_busy);
      end
    end
  end

  // Event log of the DUT outputs for the literal checks.
  int   vq_d[$];
  int   vq_c[$];
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   busy_cnt = 0;
  logic prev_v = 1'b0;

  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1 && prev_v !== 1'b1) begin
      vq_d.push_back(int'(data_out));
      vq_c.push_back(cyc);
    end
    prev_v = data_valid_out;
    if (framing_err_out === 1'b1) fe_cnt++;
    if (overrun_out === 1'b1) ov_cnt++;
    if (busy_out === 1'b1) busy_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_in = 1'b0;
    tick(BP);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(BP);
    end
    rx_in = stop_bit;
    tick(BP);
    rx_in = 1'b1;
  endtask

  initial begin
    int base, fe0, ov0, bsy0, s0, s1, gap;
    logic [7:0] rb;
    logic       rs;

    rx_in = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("reset_outputs", {23'd0, data_out, data_valid_out, framing_err_out, overrun_out, busy_out}, 32'd0);

    // Release with the line already low: no frame may start.
    rst_n_in = 1'b1;
    tick(2 * BP);
    check("low_after_reset_busy", {31'd0, busy_out}, 32'd0);
    check("low_after_reset_nobyte", vq_d.size(), 0);
    rx_in = 1'b1;
    tick(BP);

    // Two good bytes with ready high; latency = 2 sync + 1 edge + 16 + 9*32 = 307.
    data_ready_in = 1'b1;
    base = vq_d.size(); fe0 = fe_cnt;
    s0 = cyc; send_frame(8'h55, 1'b1);
    s1 = cyc; send_frame(8'hA3, 1'b1);
    tick(40);
    check("t1_count", vq_d.size() - base, 2);
    if (vq_d.size() - base == 2) begin
      check("t1_byte0", vq_d[base], 32'h55);
      check("t1_lat0", vq_c[base] - s0, 307);
      check("t1_byte1", vq_d[base + 1], 32'hA3);
      check("t1_lat1", vq_c[base + 1] - s1, 307);
    end
    check("t1_no_ferr", fe_cnt - fe0, 0);

    // Short glitch: busy for exactly half a bit, nothing else.
    base = vq_d.size(); fe0 = fe_cnt; bsy0 = busy_cnt;
    rx_in = 1'b0; tick(HALF - 4);
    rx_in = 1'b1; tick(BP);
    check("t2_no_byte", vq_d.size() - base, 0);
    check("t2_no_ferr", fe_cnt - fe0, 0);
    check("t2_busy_cycles", busy_cnt - bsy0, HALF);

    // Framing error, then recovery.
    base = vq_d.size(); fe0 = fe_cnt;
    send_frame(8'h7E, 1'b0);
    tick(BP);
    check("t3_ferr_pulses", fe_cnt - fe0, 1);
    check("t3_no_byte", vq_d.size() - base, 0);
    send_frame(8'h01, 1'b1);
    tick(40);
    check("t3_next_count", vq_d.size() - base, 1);
    if (vq_d.size() - base == 1) check("t3_next_byte", vq_d[base], 32'h01);

    // Overrun with consumer stalled.
    data_ready_in = 1'b0; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    check("t4_held_data", data_out, 32'h11);
    check("t4_valid", {31'd0, data_valid_out}, 32'd1);
    check("t4_overrun_pulses", ov_cnt - ov0, 1);
    data_ready_in = 1'b1;
    tick(1);
    data_ready_in = 1'b0;
    check("t4_valid_drop", {31'd0, data_valid_out}, 32'd0);

    // Accept in the exact completion cycle of the next byte.
    send_frame(8'h33, 1'b1);
    tick(20);
    ov0 = ov_cnt;
    fork
      send_frame(8'h44, 1'b1);
      begin
        tick(306);
        data_ready_in = 1'b1;
        tick(1);
        data_ready_in = 1'b0;
      end
    join
    tick(20);
    check("t5_data", data_out, 32'h44);
    check("t5_valid", {31'd0, data_valid_out}, 32'd1);
    check("t5_no_overrun", ov_cnt - ov0, 0);
    data_ready_in = 1'b1; tick(1); data_ready_in = 1'b0;

    // Reset in the middle of bit 4 while a byte is pending.
    send_frame(8'hC3, 1'b1);
    tick(10);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        tick(5 * BP + HALF);
        rst_n_in = 1'b0;
        #1;
        check("t6_reset_outputs", {23'd0, data_out, data_valid_out, framing_err_out, overrun_out, busy_out}, 32'd0);
      end
    join
    tick(5);
    rst_n_in = 1'b1;
    tick(5);
    data_ready_in = 1'b1;
    base = vq_d.size();
    send_frame(8'h9C, 1'b1);
    tick(40);
    check("t6_count", vq_d.size() - base, 1);
    if (vq_d.size() - base == 1) check("t6_byte", vq_d[base], 32'h9C);

    // Randomized traffic: bytes, bad stops, gaps, glitches and ready.
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 9) != 0);
      fork
        send_frame(rb, rs);
        begin
          for (int k = 0; k < 10 * BP; k++) begin
            data_ready_in = ($urandom_range(0, 3) != 0);
            tick(1);
          end
        end
      join
      if ($urandom_range(0, 4) == 0) begin
        rx_in = 1'b0;
        tick($urandom_range(1, HALF - 2));
        rx_in = 1'b1;
        tick(BP + HALF);
      end
      gap = $urandom_range(0, 40);
      for (int k = 0; k < gap; k++) begin
        data_ready_in = ($urandom_range(0, 1) != 0);
        tick(1);
      end
    end
    data_ready_in = 1'b1;
    tick(11 * BP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
